// File: rtl/sd_drive_arbiter_pkg.sv
// Shared types and widths for the SD drive arbiter slice.
package sd_drive_arbiter_pkg;

   localparam int LBA_W  = 32;
   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      XFER = 2'd2,
      DONE = 2'd3
   } arb_state_t;

endpackage

// File: rtl/sd_drive_arbiter_if.sv
// Host block-IO channel: the arbiter is the master issuing requests, the host IO port is the slave.
interface sd_drive_arbiter_if #(
   parameter int IDX_W = 1
) ();
   import sd_drive_arbiter_pkg::*;

   logic [LBA_W-1:0]  sd_lba;
   logic              sd_rd;
   logic              sd_wr;
   logic [IDX_W-1:0]  sd_drive;
   logic              sd_ack;
   logic              sd_ack_conf;
   logic [BYTE_W-1:0] sd_buff_din;

   modport master (
      output sd_lba, sd_rd, sd_wr, sd_drive, sd_buff_din,
      input  sd_ack, sd_ack_conf
   );

   modport slave (
      input  sd_lba, sd_rd, sd_wr, sd_drive, sd_buff_din,
      output sd_ack, sd_ack_conf
   );
endinterface

// File: rtl/sd_drive_arbiter_req_sync.sv
// Two-flop synchroniser for one drive's {rd, wr} request levels.
module sd_drive_arbiter_req_sync (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic [1:0] d,
   output logic [1:0] q
);
   logic [1:0] meta;

   // Bring the clk_spi request levels into clk_sys
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/sd_drive_arbiter.sv
// Round-robin arbiter sharing the host block-IO channel among NUM_DRIVES sd_card clients.
module sd_drive_arbiter
   import sd_drive_arbiter_pkg::*;
#(
   parameter int NUM_DRIVES = 2,
   parameter int IDX_W      = 1
) (
   input  logic                         clk_sys,
   input  logic                         reset_n,
   input  logic [LBA_W*NUM_DRIVES-1:0]  drv_lba,
   input  logic [NUM_DRIVES-1:0]        drv_rd,
   input  logic [NUM_DRIVES-1:0]        drv_wr,
   output logic [NUM_DRIVES-1:0]        drv_ack,
   output logic [NUM_DRIVES-1:0]        drv_ack_conf,
   input  logic [BYTE_W*NUM_DRIVES-1:0] drv_buff_din,
   input  logic [IDX_W-1:0]             conf_drive,
   sd_drive_arbiter_if.master           host
);
   arb_state_t            state;
   logic [IDX_W-1:0]      rr_ptr;
   logic [IDX_W-1:0]      g;
   logic [IDX_W-1:0]      pick;
   logic [IDX_W-1:0]      nxt_ptr;
   logic [IDX_W:0]        scan;
   logic                  pick_valid;
   logic                  pick_rd;
   logic                  g_busy;
   logic [NUM_DRIVES-1:0] rq_rd;
   logic [NUM_DRIVES-1:0] rq_wr;
   logic [NUM_DRIVES-1:0] pending;
   logic [NUM_DRIVES-1:0] pick_hot;
   logic [NUM_DRIVES-1:0] g_hot;
   logic [LBA_W-1:0]      pick_lba;

   for (genvar i = 0; i < NUM_DRIVES; i++) begin : g_sync
      logic [1:0] rq_pair;
      sd_drive_arbiter_req_sync u_sync (
         .clk_sys (clk_sys),
         .reset_n (reset_n),
         .d       ({drv_rd[i], drv_wr[i]}),
         .q       (rq_pair)
      );
      assign rq_rd[i] = rq_pair[1];
      assign rq_wr[i] = rq_pair[0];
   end

   assign pending       = rq_rd | rq_wr;
   assign pick_rd       = |(rq_rd & pick_hot);
   assign g_busy        = |(pending & g_hot);
   assign nxt_ptr       = (g == IDX_W'(NUM_DRIVES - 1)) ? '0 : g + 1'b1;
   assign host.sd_drive = g;

   // First pending drive scanning upward from rr_ptr with wrap
   always_comb begin
      pick_valid = 1'b0;
      pick       = '0;
      scan       = '0;
      for (int unsigned k = 0; k < NUM_DRIVES; k++) begin
         scan = {1'b0, rr_ptr} + (IDX_W+1)'(k);
         if (scan >= (IDX_W+1)'(NUM_DRIVES)) scan = scan - (IDX_W+1)'(NUM_DRIVES);
         if (!pick_valid && pending[scan[IDX_W-1:0]]) begin
            pick_valid = 1'b1;
            pick       = scan[IDX_W-1:0];
         end
      end
   end

   // One-hot decodes of candidate/granted drive and the per-drive lba/data muxes
   always_comb begin
      pick_hot         = '0;
      g_hot            = '0;
      pick_lba         = '0;
      host.sd_buff_din = '0;
      for (int unsigned i = 0; i < NUM_DRIVES; i++) begin
         pick_hot[i] = (pick == IDX_W'(i));
         g_hot[i]    = (g == IDX_W'(i));
         if (pick == IDX_W'(i)) pick_lba = drv_lba[LBA_W*i +: LBA_W];
         if (g == IDX_W'(i)) host.sd_buff_din = drv_buff_din[BYTE_W*i +: BYTE_W];
      end
   end

   // Config-buffer ack steering, independent of the request FSM
   always_comb begin
      drv_ack_conf = '0;
      for (int unsigned i = 0; i < NUM_DRIVES; i++) begin
         drv_ack_conf[i] = host.sd_ack_conf && (conf_drive == IDX_W'(i));
      end
   end

   // Grant FSM with registered host request and per-drive ack outputs
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         g           <= '0;
         host.sd_lba <= '0;
         host.sd_rd  <= 1'b0;
         host.sd_wr  <= 1'b0;
         drv_ack     <= '0;
      end else begin
         case (state)
            IDLE: begin
               drv_ack <= '0;
               if (!host.sd_ack && pick_valid) begin
                  g           <= pick;
                  host.sd_lba <= pick_lba;
                  host.sd_rd  <= pick_rd;
                  host.sd_wr  <= !pick_rd;
                  state       <= REQ;
               end
            end
            REQ: begin
               drv_ack <= '0;
               if (host.sd_ack) begin
                  host.sd_rd <= 1'b0;
                  host.sd_wr <= 1'b0;
                  drv_ack    <= g_hot;
                  state      <= XFER;
               end
            end
            XFER: begin
               if (!host.sd_ack) begin
                  drv_ack <= '0;
                  state   <= DONE;
               end else begin
                  drv_ack <= g_hot;
               end
            end
            DONE: begin
               drv_ack <= '0;
               // hold off until the granted drive's synchronised level has dropped
               if (!g_busy) begin
                  rr_ptr <= nxt_ptr;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
